// File: rtl/serial_mod_checker.sv
// Multi-channel bit-serial divisibility checker: each channel tracks the running
// remainder of a serially arriving number modulo DIVISOR, MSB- or LSB-first per frame.
module serial_mod_checker #(
  parameter int DIVISOR  = 5,
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8,
  localparam int RW      = $clog2(DIVISOR)
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [CHANNELS-1:0]       din,
  input  logic [CHANNELS-1:0]       valid,
  input  logic [CHANNELS-1:0]       start,
  input  logic [CHANNELS-1:0]       lsb_first,
  output logic [CHANNELS-1:0]       out_valid,
  output logic [CHANNELS-1:0]       dout,
  output logic [CHANNELS*RW-1:0]    rem,
  output logic [CHANNELS*CNT_W-1:0] bit_cnt
);

  generate
    if (DIVISOR < 2 || DIVISOR > 255) begin : g_bad_divisor
      $error("serial_mod_checker: DIVISOR must be in 2..255");
    end
    if (CHANNELS < 1) begin : g_bad_channels
      $error("serial_mod_checker: CHANNELS must be at least 1");
    end
  endgenerate

  localparam logic [RW:0]      DIV_X   = (RW+1)'(DIVISOR);
  localparam logic [RW-1:0]    WT_ONE  = RW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Inputs are always below 2*DIVISOR, so a single conditional subtract suffices.
  function automatic logic [RW-1:0] reduce(input logic [RW:0] x);
    logic [RW:0] t;
    t = (x >= DIV_X) ? (x - DIV_X) : x;
    return t[RW-1:0];
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [RW-1:0]    rem_reg;
      logic [RW-1:0]    rem_next;
      logic [RW-1:0]    wt_reg;
      logic [RW-1:0]    wt_next;
      logic [RW-1:0]    base_rem;
      logic [RW-1:0]    base_wt;
      logic             mode_reg;
      logic             mode_next;
      logic [CNT_W-1:0] cnt_reg;
      logic [CNT_W-1:0] cnt_next;
      logic             out_valid_reg;
      logic             dout_reg;
      logic [RW:0]      sum_msb;
      logic [RW:0]      sum_lsb;
      logic [RW:0]      dbl_wt;

      // A start beat behaves as the first bit of a fresh frame in the newly chosen order.
      always_comb begin
        base_rem  = start[gi] ? '0 : rem_reg;
        base_wt   = start[gi] ? WT_ONE : wt_reg;
        mode_next = start[gi] ? lsb_first[gi] : mode_reg;
        sum_msb   = {base_rem, din[gi]};
        sum_lsb   = {1'b0, base_rem} + (din[gi] ? {1'b0, base_wt} : '0);
        dbl_wt    = {base_wt, 1'b0};
        case (mode_next)
          1'b0:    rem_next = reduce(sum_msb);
          1'b1:    rem_next = reduce(sum_lsb);
          default: rem_next = '0;
        endcase
        wt_next = (mode_next || start[gi]) ? reduce(dbl_wt) : wt_reg;
        if (start[gi]) begin
          cnt_next = CNT_ONE;
        end else if (cnt_reg == CNT_MAX) begin
          cnt_next = cnt_reg;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end

      always_ff @(posedge clk) begin
        if (!resetn) begin
          rem_reg       <= '0;
          wt_reg        <= WT_ONE;
          mode_reg      <= 1'b0;
          cnt_reg       <= '0;
          out_valid_reg <= 1'b0;
          dout_reg      <= 1'b0;
        end else begin
          out_valid_reg <= valid[gi];
          if (valid[gi]) begin
            rem_reg  <= rem_next;
            wt_reg   <= wt_next;
            mode_reg <= mode_next;
            cnt_reg  <= cnt_next;
            dout_reg <= (rem_next == '0);
          end
        end
      end

      assign out_valid[gi]             = out_valid_reg;
      assign dout[gi]                  = dout_reg;
      assign rem[gi*RW +: RW]          = rem_reg;
      assign bit_cnt[gi*CNT_W +: CNT_W] = cnt_reg;
    end
  endgenerate

endmodule

// File: tb/tb_serial_mod_checker.sv
// Bench for serial_mod_checker: table vectors, directed multi-cycle sequences and
// randomized traffic against a bit-list reference model on three elaborations.
module tb_serial_mod_checker;

  localparam int ND = 3;
  localparam int NCH [ND]  = '{4, 1, 2};
  localparam int DIV [ND]  = '{5, 3, 7};
  localparam int CMAX [ND] = '{255, 3, 255};

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [3:0] din_v [ND];
  logic [3:0] vld_v [ND];
  logic [3:0] st_v  [ND];
  logic [3:0] lsb_v [ND];

  logic [3:0]  ov5, dout5;
  logic [11:0] rem5;
  logic [31:0] cnt5;
  logic [0:0]  ov3, dout3;
  logic [1:0]  rem3;
  logic [1:0]  cnt3;
  logic [1:0]  ov7, dout7;
  logic [5:0]  rem7;
  logic [15:0] cnt7;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_mod_checker #(.DIVISOR(5), .CHANNELS(4), .CNT_W(8)) dut (
    .clk(clk), .resetn(resetn), .din(din_v[0]), .valid(vld_v[0]), .start(st_v[0]),
    .lsb_first(lsb_v[0]), .out_valid(ov5), .dout(dout5), .rem(rem5), .bit_cnt(cnt5));

  serial_mod_checker #(.DIVISOR(3), .CHANNELS(1), .CNT_W(2)) dut3 (
    .clk(clk), .resetn(resetn), .din(din_v[1][0:0]), .valid(vld_v[1][0:0]),
    .start(st_v[1][0:0]), .lsb_first(lsb_v[1][0:0]), .out_valid(ov3), .dout(dout3),
    .rem(rem3), .bit_cnt(cnt3));

  serial_mod_checker #(.DIVISOR(7), .CHANNELS(2), .CNT_W(8)) dut7 (
    .clk(clk), .resetn(resetn), .din(din_v[2][1:0]), .valid(vld_v[2][1:0]),
    .start(st_v[2][1:0]), .lsb_first(lsb_v[2][1:0]), .out_valid(ov7), .dout(dout7),
    .rem(rem7), .bit_cnt(cnt7));

  // Reference model: the list of bits of the current frame plus its order.
  bit bits_q [ND][4][$];
  bit mode_m [ND][4];
  int exp_ov [ND][4];
  int exp_rem [ND][4];
  int exp_dout [ND][4];
  int exp_cnt [ND][4];

  function automatic int pow2mod(int k, int d);
    int r = 1;
    repeat (k) r = (r * 2) % d;
    return r;
  endfunction

  function automatic int model_value_mod(int d, int c);
    int n = bits_q[d][c].size();
    int s = 0;
    for (int i = 0; i < n; i++) begin
      if (bits_q[d][c][i]) s += mode_m[d][c] ? pow2mod(i, DIV[d]) : pow2mod(n - 1 - i, DIV[d]);
    end
    return s % DIV[d];
  endfunction

  function automatic int get_ov(int d, int c);
    case (d)
      0: return int'(ov5[c]);
      1: return int'(ov3[0]);
      default: return int'(ov7[c]);
    endcase
  endfunction

  function automatic int get_dout(int d, int c);
    case (d)
      0: return int'(dout5[c]);
      1: return int'(dout3[0]);
      default: return int'(dout7[c]);
    endcase
  endfunction

  function automatic int get_rem(int d, int c);
    case (d)
      0: return int'(rem5[c*3 +: 3]);
      1: return int'(rem3);
      default: return int'(rem7[c*3 +: 3]);
    endcase
  endfunction

  function automatic int get_cnt(int d, int c);
    case (d)
      0: return int'(cnt5[c*8 +: 8]);
      1: return int'(cnt3);
      default: return int'(cnt7[c*8 +: 8]);
    endcase
  endfunction

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  task automatic model_update();
    for (int d = 0; d < ND; d++) begin
      for (int c = 0; c < NCH[d]; c++) begin
        if (!resetn) begin
          bits_q[d][c].delete();
          mode_m[d][c] = 1'b0;
          exp_ov[d][c] = 0; exp_rem[d][c] = 0; exp_dout[d][c] = 0; exp_cnt[d][c] = 0;
        end else if (vld_v[d][c]) begin
          if (st_v[d][c]) begin
            bits_q[d][c].delete();
            mode_m[d][c] = lsb_v[d][c];
          end
          bits_q[d][c].push_back(din_v[d][c]);
          exp_ov[d][c]   = 1;
          exp_rem[d][c]  = model_value_mod(d, c);
          exp_dout[d][c] = (exp_rem[d][c] == 0) ? 1 : 0;
          exp_cnt[d][c]  = (bits_q[d][c].size() > CMAX[d]) ? CMAX[d] : bits_q[d][c].size();
        end else begin
          exp_ov[d][c] = 0;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < ND; d++) begin
      for (int c = 0; c < NCH[d]; c++) begin
        chk($sformatf("model_ov_d%0d_c%0d", DIV[d], c), get_ov(d, c), exp_ov[d][c]);
        chk($sformatf("model_rem_d%0d_c%0d", DIV[d], c), get_rem(d, c), exp_rem[d][c]);
        chk($sformatf("model_dout_d%0d_c%0d", DIV[d], c), get_dout(d, c), exp_dout[d][c]);
        chk($sformatf("model_cnt_d%0d_c%0d", DIV[d], c), get_cnt(d, c), exp_cnt[d][c]);
      end
    end
  endtask

  task automatic clear_inputs();
    for (int d = 0; d < ND; d++) begin
      din_v[d] = '0; vld_v[d] = '0; st_v[d] = '0; lsb_v[d] = '0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_update();
    check_all();
  endtask

  task automatic drive(input int d, input int c, input bit b, input bit v, input bit s, input bit l);
    din_v[d][c] = b; vld_v[d][c] = v; st_v[d][c] = s; lsb_v[d][c] = l;
  endtask

  typedef struct {
    bit rst_n; bit din; bit vld; bit st; bit lsb;
    int e_ov; int e_rem; int e_dout; int e_cnt;
  } vec_t;

  vec_t tbl [23];
  int ch3_rem [5] = '{1, 3, 2, 0, 1};
  int d3_rem [5]  = '{1, 0, 1, 2, 2};
  int d3_dout [5] = '{0, 1, 0, 0, 0};
  int d3_cnt [5]  = '{1, 2, 3, 3, 3};
  int d7_rem [4]  = '{1, 3, 0, 1};
  int d7_dout [4] = '{0, 0, 1, 0};

  initial begin
    clear_inputs();
    // rst_n din vld st lsb | ov rem dout cnt   (DIVISOR 5, channel 0)
    tbl[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 1, 1, 1, 0, 1, 1, 0, 1};
    tbl[2]  = '{1, 0, 1, 0, 0, 1, 2, 0, 2};
    tbl[3]  = '{1, 1, 1, 0, 0, 1, 0, 1, 3};
    tbl[4]  = '{1, 0, 1, 0, 0, 1, 0, 1, 4};
    tbl[5]  = '{1, 1, 1, 1, 1, 1, 1, 0, 1};
    tbl[6]  = '{1, 1, 1, 0, 0, 1, 3, 0, 2};
    tbl[7]  = '{1, 1, 1, 0, 0, 1, 2, 0, 3};
    tbl[8]  = '{1, 1, 1, 0, 0, 1, 0, 1, 4};
    tbl[9]  = '{1, 1, 1, 1, 1, 1, 1, 0, 1};
    tbl[10] = '{1, 0, 1, 0, 0, 1, 1, 0, 2};
    tbl[11] = '{1, 1, 1, 0, 0, 1, 0, 1, 3};
    tbl[12] = '{1, 1, 1, 1, 0, 1, 1, 0, 1};
    tbl[13] = '{1, 0, 0, 0, 0, 0, 1, 0, 1};
    tbl[14] = '{1, 0, 0, 1, 1, 0, 1, 0, 1};
    tbl[15] = '{1, 1, 0, 0, 0, 0, 1, 0, 1};
    tbl[16] = '{1, 1, 1, 0, 0, 1, 3, 0, 2};
    tbl[17] = '{1, 0, 1, 1, 0, 1, 0, 1, 1};
    tbl[18] = '{1, 1, 1, 0, 0, 1, 1, 0, 2};
    tbl[19] = '{0, 1, 1, 1, 1, 0, 0, 0, 0};
    tbl[20] = '{1, 1, 1, 0, 0, 1, 1, 0, 1};
    tbl[21] = '{1, 1, 1, 0, 0, 1, 3, 0, 2};
    tbl[22] = '{1, 0, 0, 0, 0, 0, 3, 0, 2};

    for (int i = 0; i < 23; i++) begin
      resetn = tbl[i].rst_n;
      drive(0, 0, tbl[i].din, tbl[i].vld, tbl[i].st, tbl[i].lsb);
      step();
      chk($sformatf("vec%0d_ov", i), get_ov(0, 0), tbl[i].e_ov);
      chk($sformatf("vec%0d_rem", i), get_rem(0, 0), tbl[i].e_rem);
      chk($sformatf("vec%0d_dout", i), get_dout(0, 0), tbl[i].e_dout);
      chk($sformatf("vec%0d_cnt", i), get_cnt(0, 0), tbl[i].e_cnt);
      $display("vec %0d: ov=%0d rem=%0d dout=%0d cnt=%0d", i, get_ov(0, 0), get_rem(0, 0),
               get_dout(0, 0), get_cnt(0, 0));
    end

    // Four channels at once with mixed orders; channel 2 stays idle.
    clear_inputs();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      clear_inputs();
      if (k < 3) begin
        drive(0, 0, (k != 1), 1'b1, (k == 0), 1'b0);
        drive(0, 1, (k != 1), 1'b1, (k == 0), 1'b1);
      end
      drive(0, 3, 1'b1, 1'b1, (k == 0), 1'b0);
      step();
      chk($sformatf("multi_ch3_rem%0d", k), get_rem(0, 3), ch3_rem[k]);
      chk($sformatf("multi_ch2_ov%0d", k), get_ov(0, 2), 0);
      chk($sformatf("multi_ch2_rem%0d", k), get_rem(0, 2), 0);
      if (k == 2) begin
        chk("multi_ch0_dout", get_dout(0, 0), 1);
        chk("multi_ch1_dout", get_dout(0, 1), 1);
      end
      $display("multi %0d: rem0=%0d rem1=%0d rem3=%0d", k, get_rem(0, 0), get_rem(0, 1),
               get_rem(0, 3));
    end

    // DIVISOR 3 with a 2-bit counter: saturation while the remainder keeps tracking.
    for (int k = 0; k < 5; k++) begin
      clear_inputs();
      drive(1, 0, (k != 3), 1'b1, (k == 0), 1'b0);
      step();
      chk($sformatf("d3_rem%0d", k), get_rem(1, 0), d3_rem[k]);
      chk($sformatf("d3_dout%0d", k), get_dout(1, 0), d3_dout[k]);
      chk($sformatf("d3_cnt%0d", k), get_cnt(1, 0), d3_cnt[k]);
      $display("d3 %0d: rem=%0d dout=%0d cnt=%0d", k, get_rem(1, 0), get_dout(1, 0),
               get_cnt(1, 0));
    end

    // DIVISOR 7 LSB-first: weights cycle 1,2,4,1.
    for (int k = 0; k < 4; k++) begin
      clear_inputs();
      drive(2, 0, 1'b1, 1'b1, (k == 0), 1'b1);
      step();
      chk($sformatf("d7_rem%0d", k), get_rem(2, 0), d7_rem[k]);
      chk($sformatf("d7_dout%0d", k), get_dout(2, 0), d7_dout[k]);
      $display("d7 %0d: rem=%0d dout=%0d", k, get_rem(2, 0), get_dout(2, 0));
    end

    // Randomized traffic on every channel of every elaboration.
    for (int n = 0; n < 600; n++) begin
      clear_inputs();
      resetn = ($urandom_range(63) != 0);
      for (int d = 0; d < ND; d++) begin
        for (int c = 0; c < NCH[d]; c++) begin
          drive(d, c, 1'($urandom_range(1)), ($urandom_range(3) != 0),
                ($urandom_range(7) == 0), 1'($urandom_range(1)));
        end
      end
      step();
      $display("rand %0d: rst_n=%0d d5c0 rem=%0d cnt=%0d d7c1 rem=%0d", n, resetn,
               get_rem(0, 0), get_cnt(0, 0), get_rem(2, 1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_mod_checker.md
Name: serial_mod_checker

Overview:
- Multi-channel bit-serial divisibility checker: each channel accumulates a serially arriving binary number and reports its running remainder modulo a compile-time DIVISOR, plus a "divisible" flag.
- Each channel selects MSB-first or LSB-first bit order per frame, has a valid qualifier and a frame-start marker, and keeps a saturating bit count.
- Sits in the serial-ingress datapath as a generalised replacement for single-channel, fixed-divisor, MSB-only remainder trackers.

Parameters:
- DIVISOR, 5, modulus; legal range 2..255; elaboration error outside this range.
- CHANNELS, 4, number of independent serial channels; must be at least 1.
- RW, $clog2(DIVISOR), remainder width; derived, not overridden.
- CNT_W, 8, bit-counter width per channel.

Ports:
- clk  input  1  clock, rising edge.
- resetn  input  1  synchronous, active-low reset.
- din  input  CHANNELS  serial data bit, one per channel.
- valid  input  CHANNELS  din[c] is accepted on this edge when set.
- start  input  CHANNELS  qualified by valid[c]; the bit is the first bit of a new number.
- lsb_first  input  CHANNELS  bit order; sampled only on a start beat.
- out_valid  output  CHANNELS  1-cycle pulse, one per accepted bit.
- dout  output  CHANNELS  set when the accumulated value mod DIVISOR == 0.
- rem  output  CHANNELS*RW  running remainder; channel c occupies bits [c*RW +: RW].
- bit_cnt  output  CHANNELS*CNT_W  number of bits accepted in the current frame, saturating.

Behaviour:
- Per-channel state:
  - rem_q, range 0..DIVISOR-1.
  - wt_q, equal to 2^k mod DIVISOR; used in LSB mode only.
  - mode_q, 0 = MSB-first, 1 = LSB-first.
  - cnt_q.
- Reset (resetn=0 at a clock edge), all channels:
  - rem_q=0, wt_q=1, mode_q=0, cnt_q=0.
  - dout=0, out_valid=0.
  - Reset has priority over valid and start. Reset mid-frame discards all history.
- Idle (valid[c]=0): all state holds; dout, rem and bit_cnt hold their last values; out_valid[c]=0.
- Accepted beat (valid[c]=1), in MSB mode:
  - nxt = 2*rem_q + din.
  - Subtract DIVISOR once if nxt >= DIVISOR.
  - Intermediate width RW+1 is sufficient.
- Accepted beat in LSB mode:
  - nxt = rem_q + (din ? wt_q : 0), with one conditional subtract.
  - wt_q <= 2*wt_q mod DIVISOR, with one conditional subtract.
- Start beat (valid[c]=1 and start[c]=1):
  - History is cleared first: the bit is treated as the first bit with rem_q=0 and wt_q=1.
  - mode_q <= lsb_first[c]; the new mode applies to this bit.
  - After the beat: rem = din, cnt = 1, wt_q = 2 mod DIVISOR.
  - start[c] with valid[c]=0 is ignored.
- Bit counter:
  - cnt_q increments on each accepted non-start beat and saturates at 2^CNT_W-1.
  - Remainder tracking continues after saturation.
- Latency: outputs are registered, one cycle after the accepted edge.
  - out_valid[c]=1, rem=nxt, dout=(nxt==0), bit_cnt updated, all in the cycle following acceptance.
- Streams without an initial start continue from the reset or previous state; after reset this is MSB mode with rem=0.
- Channels are fully independent. Simultaneous beats on all channels with mixed modes are legal.
- The remainder never leaves 0..DIVISOR-1. No illegal state is reachable, and the default branch of any case statement returns to rem=0.

Test Plan:
- DIVISOR=5, channel 0, MSB-first; start on the first bit, din 1,0,1,0 on consecutive valid cycles -> rem 1,2,0,0; dout 0,0,1,1; bit_cnt 1,2,3,4; out_valid high for 4 cycles.
- DIVISOR=5, LSB-first (lsb_first=1 with start); din 1,1,1,1 (value 15) -> rem 1,3,2,0; dout set only after the 4th bit. Then din 1,0,1 with a new start (value 5) -> rem 1,1,0.
- Valid gaps: MSB din 1,(gap x3),1 (value 3) -> out_valid only on the 2 accepted beats; rem holds 1 during the gap, then 3. A start pulse with valid=0 during the gap has no effect.
- Mid-frame restart: MSB stream 1,1 (rem 3), then start with din=0 -> rem 0, dout=1, bit_cnt=1. Then resetn low for 1 cycle mid-stream -> all outputs 0, rem 0, next unstarted bit uses MSB mode.
- 4 channels simultaneously: ch0 MSB 1,0,1; ch1 LSB 1,0,1; ch2 idle; ch3 MSB 1,1,1,1,1 (value 31) -> ch0/ch1 dout=1 after bit 3; ch2 outputs unchanged; ch3 rem 1,3,2,0,1.
- Re-elaborate with DIVISOR=3, CNT_W=2: MSB 1,1 -> dout=1. Feed 5 bits -> bit_cnt saturates at 3 and rem stays correct. DIVISOR=7: LSB weights cycle 1,2,4,1.
